keycode_channel_alloc: RTL

- Sits between the PS/2 keyboard byte receiver and the four-channel staff/tone front end.
- Turns the raw PS/2 set-2 byte stream (make codes, F0 break prefix, E0 extended prefix) into four held-key registers, scan_code1..scan_code4. A value of 8'hF0 in a register means that channel is silent.
- Gives up to 4-note polyphony: lowest-free-channel allocation on key press, LRU stealing when all four channels are busy, release on the matching break code.
- A no-activity watchdog releases every channel if a break code is lost.

---
 rtl/keycode_channel_alloc_pkg.sv | 22 ++
 rtl/keycode_channel_alloc_ch_lru_select.sv | 47 ++++
 rtl/keycode_channel_alloc.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/keycode_channel_alloc_pkg.sv
// Shared PS/2 set-2 constants and FSM encoding for the keycode channel allocator.
package keycode_channel_alloc_pkg;

  localparam logic [7:0] KB_BRK    = 8'hF0;  // break prefix
  localparam logic [7:0] KB_EXT    = 8'hE0;  // extended prefix
  localparam logic [7:0] CH_SILENT = 8'hF0;  // channel holds no key

  localparam int unsigned DEF_TIMEOUT_CYC = 50_000_000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_e;

  // Plain key codes live below 8'h80; everything above is a prefix or junk.
  function automatic logic is_key(input logic [7:0] b);
    return ~b[7];
  endfunction

endpackage

// File: rtl/keycode_channel_alloc_ch_lru_select.sv
// Combinational channel lookup: key hit, lowest free channel, and LRU victim.
module keycode_channel_alloc_ch_lru_select
  import keycode_channel_alloc_pkg::*;
(
  input  logic [31:0] i_codes,       // channel n at [8n +: 8]
  input  logic [7:0]  i_ages,        // channel n at [2n +: 2]
  input  logic [7:0]  i_key,
  output logic        o_hit,
  output logic [1:0]  o_hit_idx,
  output logic        o_free_found,
  output logic [1:0]  o_free_idx,
  output logic [1:0]  o_victim_idx
);

  logic [1:0] w_best_age;

  // Scan downwards so the lowest matching index is the one that sticks.
  always_comb begin
    o_hit        = 1'b0;
    o_hit_idx    = 2'd0;
    o_free_found = 1'b0;
    o_free_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i_codes[i*8 +: 8] == i_key) begin
        o_hit     = 1'b1;
        o_hit_idx = 2'(i);
      end
      if (i_codes[i*8 +: 8] == CH_SILENT) begin
        o_free_found = 1'b1;
        o_free_idx   = 2'(i);
      end
    end
  end

  // Oldest channel wins; strict compare keeps ties on the lowest index.
  always_comb begin
    w_best_age   = i_ages[1:0];
    o_victim_idx = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (i_ages[i*2 +: 2] > w_best_age) begin
        w_best_age   = i_ages[i*2 +: 2];
        o_victim_idx = 2'(i);
      end
    end
  end

endmodule

// File: rtl/keycode_channel_alloc.sv
// PS/2 byte stream to four held-key channels with LRU stealing and idle watchdog.
module keycode_channel_alloc
  import keycode_channel_alloc_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned TO_W        = 26
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] scan_code1,
  output logic [7:0] scan_code2,
  output logic [7:0] scan_code3,
  output logic [7:0] scan_code4,
  output logic [3:0] active,
  output logic       steal,
  output logic       timeout
);

  // Fires in the idle cycle whose increment would reach TIMEOUT_CYC-1.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYC - 2);

  state_e          r_state, w_state_d;
  logic [31:0]     r_code, w_code_d;
  logic [7:0]      r_age, w_age_d;
  logic [TO_W-1:0] r_wd, w_wd_d;
  logic [3:0]      r_active, w_active_d;
  logic            r_steal, w_steal_d;
  logic            r_timeout, w_timeout_d;

  logic            w_make, w_break;
  logic            w_hit, w_free_found;
  logic [1:0]      w_hit_idx, w_free_idx, w_victim_idx, w_alloc_idx;

  keycode_channel_alloc_ch_lru_select u_sel (
    .i_codes      (r_code),
    .i_ages       (r_age),
    .i_key        (rx_data),
    .o_hit        (w_hit),
    .o_hit_idx    (w_hit_idx),
    .o_free_found (w_free_found),
    .o_free_idx   (w_free_idx),
    .o_victim_idx (w_victim_idx)
  );

  assign w_alloc_idx = w_free_found ? w_free_idx : w_victim_idx;

  // Next-state: prefix FSM, make/break channel updates, watchdog.
  always_comb begin
    w_state_d   = r_state;
    w_code_d    = r_code;
    w_age_d     = r_age;
    w_wd_d      = r_wd + TO_W'(1);
    w_steal_d   = 1'b0;
    w_timeout_d = 1'b0;
    w_make      = 1'b0;
    w_break     = 1'b0;

    if (rx_valid) begin
      w_wd_d = '0;
      unique case (r_state)
        S_IDLE: begin
          if (rx_data == KB_BRK)      w_state_d = S_BRK;
          else if (rx_data == KB_EXT) w_state_d = S_EXT;
          else if (is_key(rx_data))   w_make    = 1'b1;
        end
        S_BRK: begin
          w_state_d = S_IDLE;
          w_break   = is_key(rx_data);
        end
        S_EXT:     w_state_d = (rx_data == KB_BRK) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: w_state_d = S_IDLE;
        default:   w_state_d = S_IDLE;
      endcase
    end else if (r_wd == WD_LAST) begin
      w_state_d   = S_IDLE;
      w_code_d    = {4{CH_SILENT}};
      w_wd_d      = '0;
      w_timeout_d = 1'b1;
    end

    if (w_make) begin
      if (w_hit) begin
        // Typematic repeat only refreshes the holder's age.
        for (int i = 0; i < NUM_CH; i++) begin
          if (2'(i) == w_hit_idx) w_age_d[i*2 +: 2] = 2'd0;
        end
      end else begin
        w_steal_d = ~w_free_found;
        for (int i = 0; i < NUM_CH; i++) begin
          if (2'(i) == w_alloc_idx) begin
            w_code_d[i*8 +: 8] = rx_data;
            w_age_d[i*2 +: 2]  = 2'd0;
          end else if (r_age[i*2 +: 2] != 2'd3) begin
            w_age_d[i*2 +: 2]  = r_age[i*2 +: 2] + 2'd1;
          end
        end
      end
    end

    if (w_break) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_code[i*8 +: 8] == rx_data) w_code_d[i*8 +: 8] = CH_SILENT;
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      w_active_d[i] = (w_code_d[i*8 +: 8] != CH_SILENT);
    end
  end

  // State and registered outputs; reset drops any pending prefix.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_code    <= {4{CH_SILENT}};
      r_age     <= 8'hFF;
      r_wd      <= '0;
      r_active  <= 4'h0;
      r_steal   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_code    <= w_code_d;
      r_age     <= w_age_d;
      r_wd      <= w_wd_d;
      r_active  <= w_active_d;
      r_steal   <= w_steal_d;
      r_timeout <= w_timeout_d;
    end
  end

  assign scan_code1 = r_code[7:0];
  assign scan_code2 = r_code[15:8];
  assign scan_code3 = r_code[23:16];
  assign scan_code4 = r_code[31:24];
  assign active     = r_active;
  assign steal      = r_steal;
  assign timeout    = r_timeout;

endmodule
